// File: rtl/cic_frame_packer_pkg.sv
// Shared types and helpers for the CIC frame packer: the buffered entry layout
// and a saturating increment used by the status counters.
package cic_frame_packer_pkg;

    localparam int WIDTH = 16;

    typedef struct packed {
        logic             oflow;
        logic [WIDTH-1:0] quad;
        logic [WIDTH-1:0] inph;
    } fp_entry_t;

    // Adds one when inc is set, but never passes max_val.
    function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                            input logic [31:0] max_val,
                                            input logic        inc);
        logic [31:0] res;
        res = val;
        if (inc && (val != max_val)) begin
            res = val + 32'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/cic_fp_sync_fifo.sv
// Register-array synchronous FIFO. Pointers carry one extra wrap bit so that
// full and empty are told apart without a separate occupancy register.
module cic_fp_sync_fifo #(
    parameter  int DW    = 33,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          i_clock,
    input  logic          i_reset_n,
    input  logic          i_wr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_rd,
    output logic [DW-1:0] o_rdata,
    output logic [AW:0]   o_count,
    output logic          o_full,
    output logic          o_empty
);

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          wr_en;
    logic          rd_en;

    // Requests against a full/empty FIFO are ignored rather than corrupting state.
    assign wr_en = i_wr && !o_full;
    assign rd_en = i_rd && !o_empty;

    assign o_empty = (wr_ptr == rd_ptr);
    assign o_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign o_count = wr_ptr - rd_ptr;
    assign o_rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset: nothing is read until a pointer says it was written.
    always_ff @(posedge i_clock) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= i_wdata;
        end
    end

endmodule

// File: rtl/cic_frame_packer.sv
// Packs decimated CIC I/Q samples into a framed ready/valid stream with a
// per-word overflow bit and saturating drop / overflow status counters.
module cic_frame_packer
    import cic_frame_packer_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 16,
    parameter int FRAME_LEN = 64,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 i_clock,
    input  logic                 i_reset_n,
    input  logic [WIDTH-1:0]     i_inph,
    input  logic [WIDTH-1:0]     i_quad,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic                 i_inph_pos_oflow,
    input  logic                 i_inph_neg_oflow,
    input  logic                 i_quad_pos_oflow,
    input  logic                 i_quad_neg_oflow,
    output logic [2*WIDTH-1:0]   o_data,
    output logic                 o_oflow,
    output logic                 o_last,
    output logic                 o_valid,
    input  logic                 i_ready,
    input  logic                 i_clear_counts,
    output logic [CNT_WIDTH-1:0] o_drop_count,
    output logic [CNT_WIDTH-1:0] o_oflow_count
);

    // Handshakes: a word moves when valid and ready are both high at a rising
    // clock edge; valid never waits on ready, and a stalled word holds steady.

    typedef struct packed {
        logic             oflow;
        logic [WIDTH-1:0] quad;
        logic [WIDTH-1:0] inph;
    } entry_t;

    localparam int EW = $bits(entry_t);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = $clog2(FRAME_LEN);
    localparam logic [FW-1:0] LAST_IDX = FW'(FRAME_LEN - 1);
    localparam logic [31:0]   CNT_MAX  = 32'({CNT_WIDTH{1'b1}});

    entry_t         wr_entry;
    entry_t         head_entry;
    entry_t         out_entry;
    logic           out_valid;
    logic [FW-1:0]  frame_cnt;
    logic [AW:0]    fifo_count;
    logic           fifo_full;
    logic           fifo_empty;
    logic           wr;
    logic           drop;
    logic           hs;
    logic           load;
    logic           any_flag;

    assign any_flag = i_inph_pos_oflow | i_inph_neg_oflow | i_quad_pos_oflow | i_quad_neg_oflow;
    assign wr_entry = '{oflow: any_flag, quad: i_quad, inph: i_inph};

    // Ready comes straight from the registered occupancy, so a same-cycle read
    // of a full FIFO never opens room for a write.
    assign o_ready = (fifo_count != (AW+1)'(DEPTH));
    assign wr      = i_valid && o_ready;
    assign drop    = i_valid && fifo_full;

    assign hs   = out_valid && i_ready;
    assign load = !fifo_empty && (!out_valid || hs);

    cic_fp_sync_fifo #(
        .DW    (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_wr      (wr),
        .i_wdata   (wr_entry),
        .i_rd      (load),
        .o_rdata   (head_entry),
        .o_count   (fifo_count),
        .o_full    (fifo_full),
        .o_empty   (fifo_empty)
    );

    // Show-ahead output stage: refilled from the FIFO head as soon as it is
    // free or being consumed.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            out_entry <= '0;
            out_valid <= 1'b0;
        end else if (load) begin
            out_entry <= head_entry;
            out_valid <= 1'b1;
        end else if (hs) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            frame_cnt <= '0;
        end else if (hs) begin
            frame_cnt <= (frame_cnt == LAST_IDX) ? '0 : frame_cnt + 1'b1;
        end
    end

    // Clear takes priority over a coincident increment.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_drop_count  <= '0;
            o_oflow_count <= '0;
        end else if (i_clear_counts) begin
            o_drop_count  <= '0;
            o_oflow_count <= '0;
        end else begin
            o_drop_count  <= CNT_WIDTH'(sat_inc(32'(o_drop_count), CNT_MAX, drop));
            o_oflow_count <= CNT_WIDTH'(sat_inc(32'(o_oflow_count), CNT_MAX, wr && any_flag));
        end
    end

    assign o_valid = out_valid;
    assign o_data  = {out_entry.quad, out_entry.inph};
    assign o_oflow = out_entry.oflow;
    assign o_last  = out_valid && (frame_cnt == LAST_IDX);

endmodule

// File: tb/tb_cic_frame_packer.sv
// Randomized bench for cic_frame_packer: a queue-based reference model of the
// accepted samples, occupancy and counters checked against the DUT every cycle.
module tb_cic_frame_packer;

    localparam int W  = 16;
    localparam int D  = 16;
    localparam int FL = 4;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [W-1:0]    i_inph, i_quad;
    logic            i_valid, o_ready;
    logic            f_ip, f_in, f_qp, f_qn;
    logic [2*W-1:0]  o_data;
    logic            o_oflow, o_last, o_valid;
    logic            i_ready, i_clear;
    logic [CW-1:0]   o_drop_count, o_oflow_count;

    always #5 clk = ~clk;

    cic_frame_packer #(
        .WIDTH(W), .DEPTH(D), .FRAME_LEN(FL), .CNT_WIDTH(CW)
    ) dut (
        .i_clock          (clk),
        .i_reset_n        (rst_n),
        .i_inph           (i_inph),
        .i_quad           (i_quad),
        .i_valid          (i_valid),
        .o_ready          (o_ready),
        .i_inph_pos_oflow (f_ip),
        .i_inph_neg_oflow (f_in),
        .i_quad_pos_oflow (f_qp),
        .i_quad_neg_oflow (f_qn),
        .o_data           (o_data),
        .o_oflow          (o_oflow),
        .o_last           (o_last),
        .o_valid          (o_valid),
        .i_ready          (i_ready),
        .i_clear_counts   (i_clear),
        .o_drop_count     (o_drop_count),
        .o_oflow_count    (o_oflow_count)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: exp_q holds every accepted, not yet consumed word in
    // order; its head is the word the DUT should be presenting.
    logic [2*W:0] exp_q[$];
    int m_fifo, m_frame, m_drop, m_ocnt;
    bit m_ov;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_fifo = 0; m_frame = 0; m_drop = 0; m_ocnt = 0; m_ov = 0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_valid"}, 64'(o_valid), 64'd0);
        check({tag, "_ready"}, 64'(o_ready), 64'd1);
        check({tag, "_data"},  64'(o_data), 64'd0);
        check({tag, "_last"},  64'(o_last), 64'd0);
        check({tag, "_oflow"}, 64'(o_oflow), 64'd0);
        check({tag, "_drop"},  64'(o_drop_count), 64'd0);
        check({tag, "_ocnt"},  64'(o_oflow_count), 64'd0);
    endtask

    task automatic check_outputs();
        check("o_valid", 64'(o_valid), 64'(m_ov));
        check("o_ready", 64'(o_ready), 64'(m_fifo != D));
        if (m_ov && exp_q.size() > 0) begin
            check("o_data",  64'(o_data), 64'(exp_q[0][2*W-1:0]));
            check("o_oflow", 64'(o_oflow), 64'(exp_q[0][2*W]));
            check("o_last",  64'(o_last), 64'(m_frame == FL - 1));
        end else begin
            check("o_last_idle", 64'(o_last), 64'd0);
        end
        check("drop_count",  64'(o_drop_count), 64'(m_drop));
        check("oflow_count", 64'(o_oflow_count), 64'(m_ocnt));
    endtask

    // One clock: check, drive, advance model, then step to the next falling edge.
    task automatic cycle(input bit v, input bit rdy, input bit clr, input logic [3:0] fl);
        logic [W-1:0] di, dq;
        bit mr, wr, drop, hs, rd;
        int nd, no;
        check_outputs();
        di = W'($urandom);
        dq = W'($urandom);
        i_valid = v; i_ready = rdy; i_clear = clr;
        i_inph = di; i_quad = dq;
        {f_ip, f_in, f_qp, f_qn} = fl;
        mr   = (m_fifo != D);
        wr   = v && mr;
        drop = v && !mr;
        hs   = m_ov && rdy;
        rd   = (m_fifo > 0) && (!m_ov || hs);
        if (hs) begin
            void'(exp_q.pop_front());
            m_frame = (m_frame + 1) % FL;
        end
        if (wr) exp_q.push_back({|fl, dq, di});
        m_fifo = m_fifo + int'(wr) - int'(rd);
        if (rd) m_ov = 1;
        else if (hs) m_ov = 0;
        nd = m_drop + int'(drop);
        no = m_ocnt + int'(wr && (fl != 4'd0));
        m_drop = clr ? 0 : (nd > CMAX ? CMAX : nd);
        m_ocnt = clr ? 0 : (no > CMAX ? CMAX : no);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int k = 0; k < n; k++) cycle(1'b0, rdy, 1'b0, 4'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        i_valid = 0; i_ready = 0; i_clear = 0;
        i_inph = '0; i_quad = '0;
        {f_ip, f_in, f_qp, f_qn} = 4'd0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_reset_values("rst");
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();

        // Three samples straight through.
        for (int k = 0; k < 3; k++) cycle(1'b1, 1'b1, 1'b0, 4'd0);
        idle(4, 1'b1);

        // Nine samples across frame boundaries.
        do_reset();
        for (int k = 0; k < 9; k++) cycle(1'b1, 1'b1, 1'b0, 4'd0);
        idle(4, 1'b1);
        check("frame_cnt_9", 64'(dut.frame_cnt), 64'(m_frame));

        // Fill with the consumer stalled: 17 held, 3 dropped, then drain.
        do_reset();
        for (int k = 0; k < 20; k++) cycle(1'b1, 1'b0, 1'b0, 4'd0);
        check("drop_after_fill", 64'(o_drop_count), 64'd3);
        idle(20, 1'b1);

        // One flagged sample among clean ones.
        do_reset();
        for (int k = 0; k < 6; k++) cycle(1'b1, 1'b1, 1'b0, (k == 3) ? 4'b0001 : 4'b0000);
        idle(4, 1'b1);
        check("oflow_count_one", 64'(o_oflow_count), 64'd1);

        // Drop counter saturates, then clear beats a coincident drop.
        do_reset();
        for (int k = 0; k < 37; k++) cycle(1'b1, 1'b0, 1'b0, 4'd0);
        check("drop_saturated", 64'(o_drop_count), 64'(CMAX));
        cycle(1'b1, 1'b0, 1'b1, 4'd0);
        check("drop_cleared", 64'(o_drop_count), 64'd0);
        idle(20, 1'b1);

        // Asynchronous reset with words buffered and o_valid high.
        do_reset();
        for (int k = 0; k < 5; k++) cycle(1'b1, 1'b0, 1'b0, 4'b1000);
        idle(1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_rst");
        model_reset();
        i_valid = 0; i_ready = 0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 1'b1, 1'b0, 4'd0);
        check("frame_after_rst", 64'(dut.frame_cnt), 64'd0);
        idle(3, 1'b1);

        // Random traffic.
        for (int k = 0; k < 3000; k++) begin
            cycle($urandom_range(0, 99) < 70,
                  $urandom_range(0, 99) < 60,
                  $urandom_range(0, 199) == 0,
                  ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'd0);
        end
        idle(D + 4, 1'b1);
        check("final_frame_cnt", 64'(dut.frame_cnt), 64'(m_frame));
        check("final_queue_empty", 64'(o_valid), 64'(exp_q.size() != 0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
